pwm_peripheral: RTL and testbench

//  Output stage fed by the SPI register bank. Generates one shared 8-bit PWM waveform

---
 rtl/pwm_peripheral.sv | 131 +++++++++++++
 tb/tb_pwm_peripheral.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/pwm_peripheral.sv
// pwm_peripheral: output stage behind the SPI register bank.
//   Generates one shared 8-bit PWM waveform from pwm_duty_cycle. Each of the
//   16 pins is driven low, constant high or with that waveform, as selected
//   by its output-enable and PWM-select bits.
//   out[7:0] maps to uo_out[7:0] and out[15:8] maps to uio_out[7:0].
//
// Parameters
//   PRESCALE  clk cycles per PWM count (>=1). Period = 256*PRESCALE clk.
//
// Ports
//   clk              in   system clock
//   rst              in   async active-high reset
//   en_reg_out_7_0   in   output enable, out[7:0]
//   en_reg_out_15_8  in   output enable, out[15:8]
//   en_reg_pwm_7_0   in   PWM select, out[7:0]
//   en_reg_pwm_15_8  in   PWM select, out[15:8]
//   pwm_duty_cycle   in   duty, 0x00 = 0 %, 0xFF = 100 %
//   out              out  registered pin drive
//   period_start     out  1-clk pulse in the cycle the PWM counter becomes 0
//
// Build option
//   PWM_SYNC_UPDATE_EN: when defined, the duty is shadowed and reloaded only
//   at the 255->0 wrap, so every period uses a single duty value. When
//   undefined, the duty feeds the compare directly (fastest, runt pulses
//   possible).

// One output pin: registered select between 0, 1 and the shared PWM level.
module pwm_pin (
  input  logic clk,
  input  logic rst,
  input  logic en_out_i,
  input  logic en_pwm_i,
  input  logic pwm_lvl_i,
  output logic out_o
);
  logic out_q, out_d;

  // Output enable wins over the PWM select.
  assign out_d = en_out_i & (~en_pwm_i | pwm_lvl_i);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) out_q <= 1'b0;
    else     out_q <= out_d;
  end

  assign out_o = out_q;
endmodule

module pwm_peripheral #(
  parameter int PRESCALE = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);
  localparam int NUM_PINS = 16;
  // Keep at least one bit so PRESCALE=1 still elaborates cleanly.
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

  logic [PW-1:0]         pre_cnt_q, pre_cnt_d;
  logic [7:0]            pwm_cnt_q, pwm_cnt_d;
  logic                  period_start_q;
  logic                  tick, wrap, pwm_lvl;
  logic [7:0]            duty_act;
  logic [NUM_PINS-1:0]   en_out, en_pwm;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  // Prescaler: with PRESCALE=1 the compare is always true, so tick is
  // asserted every cycle and pre_cnt stays at 0.
  assign tick      = (pre_cnt_q == PW'(PRESCALE - 1));
  assign pre_cnt_d = tick ? '0 : pre_cnt_q + 1'b1;

  assign wrap      = tick & (pwm_cnt_q == 8'hFF);
  assign pwm_cnt_d = tick ? pwm_cnt_q + 8'd1 : pwm_cnt_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt_q      <= '0;
      pwm_cnt_q      <= '0;
      period_start_q <= 1'b0;
    end else begin
      pre_cnt_q      <= pre_cnt_d;
      pwm_cnt_q      <= pwm_cnt_d;
      period_start_q <= wrap;
    end
  end

`ifdef PWM_SYNC_UPDATE_EN
  // Shadow duty: a write coincident with the wrap already applies to the
  // new period, because it is sampled on that same edge.
  logic [7:0] duty_act_q, duty_act_d;

  assign duty_act_d = wrap ? pwm_duty_cycle : duty_act_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) duty_act_q <= 8'h00;
    else     duty_act_q <= duty_act_d;
  end

  assign duty_act = duty_act_q;
`else
  assign duty_act = pwm_duty_cycle;
`endif

  // 0xFF is forced high so that full duty has no low count at pwm_cnt=255.
  assign pwm_lvl = (duty_act == 8'hFF) | (pwm_cnt_q < duty_act);

  genvar gi;
  generate
    for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin
      pwm_pin u_pin (
        .clk       (clk),
        .rst       (rst),
        .en_out_i  (en_out[gi]),
        .en_pwm_i  (en_pwm[gi]),
        .pwm_lvl_i (pwm_lvl),
        .out_o     (out[gi])
      );
    end
  endgenerate

  assign period_start = period_start_q;
endmodule

// File: tb/tb_pwm_peripheral.sv
// Randomized and directed bench for pwm_peripheral. Two instances share the
// inputs: PRESCALE=13 and PRESCALE=1. The reference model works from the
// position inside the period (edges since reset modulo 256*P): a pin on PWM
// is high when that position is below duty*P, or always for duty 0xFF.
module tb_pwm_peripheral;
  localparam int P13 = 13;
  localparam int P1  = 1;
  localparam int PER13 = 256 * P13;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] eo = '0, ep = '0;
  logic [7:0]  duty = '0;
  logic [15:0] out13, out1;
  logic        ps13, ps1;

  int total = 0, bad = 0;

  // Model state
  int         n13 = 0, n1 = 0;
  logic [7:0] dm13 = '0, dm1 = '0;
  bit         in_rst = 1'b1;

  // Window counters
  int hi13[16];
  int ps13cnt = 0, hi1 = 0;

  always #5 clk = ~clk;

  pwm_peripheral #(.PRESCALE(P13)) u_dut13 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(eo[7:0]), .en_reg_out_15_8(eo[15:8]),
    .en_reg_pwm_7_0(ep[7:0]), .en_reg_pwm_15_8(ep[15:8]),
    .pwm_duty_cycle(duty), .out(out13), .period_start(ps13)
  );

  pwm_peripheral #(.PRESCALE(P1)) u_dut1 (
    .clk(clk), .rst(rst),
    .en_reg_out_7_0(eo[7:0]), .en_reg_out_15_8(eo[15:8]),
    .en_reg_pwm_7_0(ep[7:0]), .en_reg_pwm_15_8(ep[15:8]),
    .pwm_duty_cycle(duty), .out(out1), .period_start(ps1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Expected {period_start, out} after the next edge, given n edges so far.
  function automatic logic [16:0] exp_f(input int p, input int n, input logic [7:0] d,
                                        input logic [15:0] e_o, input logic [15:0] e_p);
    int ph;
    bit hi, ps;
    ph = n % (256 * p);
    hi = (d == 8'hFF) || (ph < int'(d) * p);
    ps = ((n + 1) % (256 * p)) == 0;
    return {ps, e_o & (~e_p | {16{hi}})};
  endfunction

  task automatic clr_cnt();
    for (int i = 0; i < 16; i++) hi13[i] = 0;
    ps13cnt = 0;
    hi1 = 0;
  endtask

  // One clock: predict, advance, compare both instances, accumulate windows.
  task automatic step();
    logic [16:0] e13, e1;
    logic [7:0]  d13, d1;
`ifdef PWM_SYNC_UPDATE_EN
    d13 = dm13; d1 = dm1;
`else
    d13 = duty; d1 = duty;
`endif
    e13 = in_rst ? 17'd0 : exp_f(P13, n13, d13, eo, ep);
    e1  = in_rst ? 17'd0 : exp_f(P1,  n1,  d1,  eo, ep);
    @(posedge clk);
    #1;
    if (!in_rst) begin
      if ((n13 + 1) % PER13 == 0) dm13 = duty;
      if ((n1 + 1) % (256 * P1) == 0) dm1 = duty;
      n13++;
      n1++;
    end
    chk("cyc13", {15'd0, ps13, out13}, {15'd0, e13});
    chk("cyc1",  {15'd0, ps1,  out1},  {15'd0, e1});
    for (int i = 0; i < 16; i++) hi13[i] += int'(out13[i]);
    ps13cnt += int'(ps13);
    hi1     += int'(out1[0]);
  endtask

  task automatic steps(input int k);
    for (int i = 0; i < k; i++) step();
  endtask

  task automatic wait_ps13();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!ps13 && k < 2 * PER13);
    if (!ps13) chk("ps13_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ps1();
    int k;
    k = 0;
    do begin
      step();
      k++;
    end while (!ps1 && k < 600);
    if (!ps1) chk("ps1_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int k;
    // Reset state
    #3;
    chk("rst_out13", {15'd0, ps13, out13}, 32'd0);
    chk("rst_out1",  {15'd0, ps1,  out1},  32'd0);
    steps(3);
    rst = 1'b0; in_rst = 1'b0;

    // 1: 50 % duty, everything on PWM
    eo = 16'hFFFF; ep = 16'hFFFF; duty = 8'h80;
    wait_ps13();
    clr_cnt(); steps(PER13);
    chk("t1_hi_b0",  hi13[0],  1664);
    chk("t1_hi_b15", hi13[15], 1664);
    chk("t1_ps_per", ps13cnt, 1);

    // 2: 0 % then 100 %
    duty = 8'h00;
    wait_ps13();
    clr_cnt(); steps(PER13);
    chk("t2_hi_0", hi13[5], 0);
    duty = 8'hFF;
    wait_ps13();
    clr_cnt(); steps(PER13);
    chk("t2_hi_ff", hi13[9], PER13);

    // 3: mixed drive
    eo = 16'h00FF; ep = 16'h000F; duty = 8'h40;
    wait_ps13();
    clr_cnt(); steps(PER13);
    chk("t3_pwm_b3",   hi13[3],  832);
    chk("t3_const_b7", hi13[7],  PER13);
    chk("t3_off_b15",  hi13[15], 0);

    // 4: duty 0x80 -> 0x20 written at pwm_cnt=0x10
    eo = 16'hFFFF; ep = 16'hFFFF; duty = 8'h80;
    wait_ps13();
    wait_ps13();
    clr_cnt(); steps(16 * P13);
    duty = 8'h20;
    steps(PER13 - 16 * P13);
`ifdef PWM_SYNC_UPDATE_EN
    chk("t4_cur_per", hi13[0], 1664);
`else
    chk("t4_cur_per", hi13[0], 416);
`endif
    clr_cnt(); steps(PER13);
    chk("t4_next_per", hi13[0], 416);

    // 5: async reset at pwm_cnt=0x90
    duty = 8'hC0;
    wait_ps13();
    steps(8'h90 * P13);
    rst = 1'b1; in_rst = 1'b1;
    n13 = 0; n1 = 0; dm13 = '0; dm1 = '0;
    #1;
    chk("t5_rst_async13", {15'd0, ps13, out13}, 32'd0);
    chk("t5_rst_async1",  {15'd0, ps1,  out1},  32'd0);
    steps(3);
    rst = 1'b0; in_rst = 1'b0;
    k = 0;
    do begin
      step();
      k++;
    end while (!ps13 && k < PER13 + 100);
    chk("t5_first_ps", k, PER13);

    // 6: PRESCALE=1 instance, one high clk per 256
    duty = 8'h01;
    wait_ps1();
    clr_cnt(); steps(256);
    chk("t6_p1_hi", hi1, 1);

    // Random register traffic
    for (int b = 0; b < 16; b++) begin
      eo = 16'($urandom);
      ep = 16'($urandom);
      case ($urandom_range(0, 3))
        0:       duty = 8'h00;
        1:       duty = 8'hFF;
        default: duty = 8'($urandom);
      endcase
      steps($urandom_range(50, 600));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
